// File: rtl/load_store_unit.sv
// Load/store initiator for a word-organised data memory: byte/halfword/word
// accesses, sub-word stores via read-modify-write, one-cycle done pulse.
module load_store_unit #(
    parameter int ADDR_W = 5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        signed_load,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

    state_t      r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;

    logic        w_reqErr;
    logic [31:0] w_wordIdx;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_loadVal;
    logic [31:0] w_mergeVal;

    always_comb begin
        w_reqErr = (size == 2'b11)
                || (size == 2'b01 && addr[0])
                || (size == 2'b10 && addr[1:0] != 2'b00)
                || (|addr[31:ADDR_W+2]);
        w_wordIdx = {{(32-ADDR_W){1'b0}}, addr[ADDR_W+1:2]};
    end

    // Lane extraction and merge both work on the word arriving at the end of CAP.
    always_comb begin
        w_byte = mem_read_data[7:0];
        case (r_lane)
            2'd1:    w_byte = mem_read_data[15:8];
            2'd2:    w_byte = mem_read_data[23:16];
            2'd3:    w_byte = mem_read_data[31:24];
            default: w_byte = mem_read_data[7:0];
        endcase
        w_half = r_lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];

        case (r_size)
            2'b00:   w_loadVal = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_loadVal = {{16{r_signed & w_half[15]}}, w_half};
            default: w_loadVal = mem_read_data;
        endcase

        w_mergeVal = mem_read_data;
        if (r_size == 2'b00) begin
            case (r_lane)
                2'd0: w_mergeVal[7:0]   = r_wdata[7:0];
                2'd1: w_mergeVal[15:8]  = r_wdata[7:0];
                2'd2: w_mergeVal[23:16] = r_wdata[7:0];
                2'd3: w_mergeVal[31:24] = r_wdata[7:0];
                default: w_mergeVal = mem_read_data;
            endcase
        end else if (r_lane[1]) begin
            w_mergeVal[31:16] = r_wdata;
        end else begin
            w_mergeVal[15:0] = r_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_we           <= 1'b0;
            r_size         <= 2'b00;
            r_signed       <= 1'b0;
            r_lane         <= 2'b00;
            r_wdata        <= 16'h0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            rdata          <= 32'h0;
            MemRead        <= 1'b0;
            MemWrite       <= 1'b0;
            mem_address    <= 32'h0;
            mem_write_data <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we     <= we;
                        r_size   <= size;
                        r_signed <= signed_load;
                        r_lane   <= addr[1:0];
                        r_wdata  <= wdata[15:0];
                        busy     <= 1'b1;
                        if (w_reqErr) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            mem_address <= w_wordIdx;
                            if (we && size == 2'b10) begin
                                r_state        <= S_WR;
                                MemWrite       <= 1'b1;
                                mem_write_data <= wdata;
                            end else begin
                                r_state <= S_RD;
                                MemRead <= 1'b1;
                            end
                        end
                    end
                end
                S_RD: begin
                    r_state <= S_CAP;
                end
                S_CAP: begin
                    MemRead <= 1'b0;
                    if (r_we) begin
                        r_state        <= S_WR;
                        MemWrite       <= 1'b1;
                        mem_write_data <= w_mergeVal;
                    end else begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        rdata   <= w_loadVal;
                    end
                end
                S_WR: begin
                    r_state  <= S_DONE;
                    MemWrite <= 1'b0;
                    done     <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected
// completions; a negedge monitor pops and compares them against the DUT.
module tb_load_store_unit;

    typedef struct {
        int          doneCyc;
        logic        err;
        logic [31:0] rdata;
        int          nRd;
        int          nWr;
        logic [31:0] wAddr;
        logic [31:0] wData;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        signed_load = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        MemRead, MemWrite;
    logic [31:0] mem_address, mem_write_data;
    logic [31:0] mem_read_data = 32'h0;

    logic [31:0] mem [0:31];
    exp_t        expQ[$];
    int          cyc = 0;
    int          nRd = 0;
    int          nWr = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] expRdata = 32'h0;

    load_store_unit #(.ADDR_W(5)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we), .size(size),
        .signed_load(signed_load), .addr(addr), .wdata(wdata), .busy(busy),
        .done(done), .err(err), .rdata(rdata), .MemRead(MemRead),
        .MemWrite(MemWrite), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Registered-read memory: data requested in RD is present during CAP.
    always @(posedge clock) begin
        if (MemRead) mem_read_data <= mem[mem_address[4:0]];
        if (MemWrite) mem[mem_address[4:0]] <= mem_write_data;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            nRd = 0;
            nWr = 0;
        end else begin
            if (MemRead) nRd++;
            if (MemWrite) begin
                nWr++;
                if (expQ.size() > 0) begin
                    checkOutput("write_addr", mem_address, expQ[0].wAddr);
                    checkOutput("write_data", mem_write_data, expQ[0].wData);
                end else begin
                    checkOutput("unexpected_write", 32'd1, 32'd0);
                end
            end
            if (done) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("done_cycle", cyc, e.doneCyc);
                    checkOutput("err", {31'b0, err}, {31'b0, e.err});
                    checkOutput("rdata", rdata, e.rdata);
                    checkOutput("memread_cycles", nRd, e.nRd);
                    checkOutput("memwrite_cycles", nWr, e.nWr);
                    checkOutput("busy_at_done", {31'b0, busy}, 32'd1);
                end
                nRd = 0;
                nWr = 0;
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'b0, done}, 32'd0);
        checkOutput({tag, "_err"}, {31'b0, err}, 32'd0);
        checkOutput({tag, "_rdata"}, rdata, 32'd0);
        checkOutput({tag, "_memread"}, {31'b0, MemRead}, 32'd0);
        checkOutput({tag, "_memwrite"}, {31'b0, MemWrite}, 32'd0);
        checkOutput({tag, "_mem_address"}, mem_address, 32'd0);
        checkOutput({tag, "_mem_write_data"}, mem_write_data, 32'd0);
    endtask

    // Issue one request, queue its expected completion, then scramble the inputs.
    task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] a, input logic [31:0] d, input int lat,
                                 input logic e, input int nr, input int nw,
                                 input logic [31:0] wa, input logic [31:0] wd);
        exp_t x;
        @(negedge clock);
        we = w; size = sz; signed_load = sg; addr = a; wdata = d; req = 1'b1;
        x.doneCyc = cyc + lat; x.err = e; x.rdata = expRdata;
        x.nRd = nr; x.nWr = nw; x.wAddr = wa; x.wData = wd;
        expQ.push_back(x);
        @(posedge clock);
        #1;
        req = 1'b0; we = ~w; size = ~sz; signed_load = ~sg; addr = 32'hFFFF_FFFF; wdata = ~d;
        repeat (lat) @(negedge clock);
    endtask

    task automatic doLoad(input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] val);
        expRdata = val;
        applyStimulus(1'b0, sz, sg, a, 32'h0, 3, 1'b0, 2, 0, 32'h0, 32'h0);
    endtask

    task automatic doSubStore(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] wa, input logic [31:0] merged);
        applyStimulus(1'b1, sz, 1'b0, a, d, 4, 1'b0, 2, 1, wa, merged);
    endtask

    task automatic doWordStore(input logic [31:0] a, input logic [31:0] d, input logic [31:0] wa);
        applyStimulus(1'b1, 2'b10, 1'b0, a, d, 2, 1'b0, 0, 1, wa, d);
    endtask

    task automatic doError(input logic w, input logic [1:0] sz, input logic [31:0] a);
        applyStimulus(w, sz, 1'b0, a, 32'h5555_5555, 1, 1'b1, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, pending %0d", expQ.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t x;
        int acc;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[1]  = 32'hCAFE_F00D;
        mem[3]  = 32'hA1B2_C3D4;
        mem[31] = 32'h8000_0001;

        #3;
        checkResetOutputs("reset");
        @(negedge clock);
        reset_n = 1'b1;

        doLoad(2'b00, 1'b1, 32'h0D, 32'hFFFF_FFC3);
        doLoad(2'b01, 1'b0, 32'h0E, 32'h0000_A1B2);
        doLoad(2'b10, 1'b0, 32'h0C, 32'hA1B2_C3D4);
        doSubStore(2'b00, 32'h0F, 32'h1234_565E, 32'd3, 32'h5EB2_C3D4);
        doLoad(2'b10, 1'b1, 32'h0C, 32'h5EB2_C3D4);
        doLoad(2'b01, 1'b1, 32'h0C, 32'hFFFF_C3D4);
        doLoad(2'b00, 1'b0, 32'h0E, 32'h0000_00B2);
        doLoad(2'b00, 1'b1, 32'h0F, 32'h0000_005E);
        doSubStore(2'b01, 32'h0E, 32'hABCD_BEEF, 32'd3, 32'hBEEF_C3D4);
        doLoad(2'b10, 1'b0, 32'h0C, 32'hBEEF_C3D4);
        doWordStore(32'h14, 32'h0BAD_F00D, 32'd5);
        doLoad(2'b10, 1'b0, 32'h14, 32'h0BAD_F00D);
        doLoad(2'b10, 1'b0, 32'h7C, 32'h8000_0001);

        doError(1'b0, 2'b10, 32'h0E);
        doError(1'b1, 2'b01, 32'h01);
        doError(1'b0, 2'b11, 32'h00);
        doError(1'b0, 2'b10, 32'h80);

        // Abort a halfword store to word 1 while it sits in CAP.
        @(negedge clock);
        we = 1'b1; size = 2'b01; signed_load = 1'b0; addr = 32'h04; wdata = 32'h0000_1111; req = 1'b1;
        @(posedge clock);
        #1 req = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 checkResetOutputs("midreset");
        expRdata = 32'h0;
        repeat (3) @(negedge clock);
        checkOutput("mem1_after_abort", mem[1], 32'hCAFE_F00D);
        reset_n = 1'b1;

        doWordStore(32'h04, 32'h1234_5678, 32'd1);
        doLoad(2'b10, 1'b0, 32'h04, 32'h1234_5678);

        // req held high across a word store followed by a word load.
        @(negedge clock);
        we = 1'b1; size = 2'b10; signed_load = 1'b0; addr = 32'h08; wdata = 32'hDEAD_BEEF; req = 1'b1;
        acc = cyc;
        x.doneCyc = acc + 2; x.err = 1'b0; x.rdata = expRdata;
        x.nRd = 0; x.nWr = 1; x.wAddr = 32'd2; x.wData = 32'hDEAD_BEEF;
        expQ.push_back(x);
        expRdata = 32'hDEAD_BEEF;
        x.doneCyc = acc + 3 + 3; x.err = 1'b0; x.rdata = expRdata;
        x.nRd = 2; x.nWr = 0; x.wAddr = 32'h0; x.wData = 32'h0;
        expQ.push_back(x);
        @(posedge clock);
        #1;
        we = 1'b0; size = 2'b10; addr = 32'h08; wdata = 32'h0F0F_0F0F;
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1;
        req = 1'b0; we = 1'b1; size = 2'b11; addr = 32'hFFFF_FFFF;
        repeat (3) @(negedge clock);

        repeat (5) @(negedge clock);
        checkOutput("pending_completions", expQ.size(), 32'd0);
        checkOutput("final_busy", {31'b0, busy}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
